// File: rtl/data_ram_async.sv
// Word-addressed data memory: synchronous full-word write, combinational read.
// Async active-low reset clears every word; addresses at or beyond DEPTH read 0 and ignore writes.
module data_ram_async #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] spo
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  // Storage starts at zero so reads are defined even before the first reset.
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH] = '{default: '0};

  logic             in_range;
  logic [IDX_W-1:0] idx;

  // Full-width compare so any set upper address bit blocks access instead of aliasing.
  assign in_range = (a < DEPTH_A);
  assign idx      = a[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we && in_range) begin
      mem_reg[idx] <= d;
    end
  end

  // Combinational read path gives write-first visibility right after the edge.
  assign spo = (rst_n && in_range) ? mem_reg[idx] : '0;

endmodule

// File: tb/tb_data_ram_async.sv
// Randomized scoreboard bench for data_ram_async against a behavioural array model.
// Stimulus pushes expected read values; a monitor process samples spo and compares.
module tb_data_ram_async;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  data_ram_async #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .d(d),
    .we(we),
    .spo(spo)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  event        chk_ev;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done  = 1'b0;
  logic [31:0] ref_mem[64];

  // Model: memory is an array of 64 words; anything outside reads 0.
  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (rst_n !== 1'b1 || addr >= 32'd64) return 32'h0;
    return ref_mem[addr[5:0]];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
  endfunction

  task automatic expect_val(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.addr = a;
    e.exp  = exp;
    sb_q.push_back(e);
    ->chk_ev;
    #2;
  endtask

  task automatic expect_model(input string name);
    expect_val(name, model_read(a));
  endtask

  // One clock edge: apply the write rule to the model, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1 && we && a < 32'd64) ref_mem[a[5:0]] = d;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (spo !== e.exp) begin
          n_bad++;
          $display("FAIL %s: a=%h spo=%h expected=%h", e.name, e.addr, spo, e.exp);
        end else begin
          $display("ok   %s: a=%h spo=%h", e.name, e.addr, spo);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin : stim
    int r;
    model_clear();
    rst_n = 1'b0;
    we    = 1'b1;
    a     = 32'd5;
    d     = 32'hDEADBEEF;
    repeat (2) tick();
    #1;
    n_cmp++;
    if (spo !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_direct: a=%h spo=%h expected=%h", a, spo, 32'h0);
    end else begin
      $display("ok   reset_direct: a=%h spo=%h", a, spo);
    end
    expect_val("reset_hold", 32'h0);
    rst_n = 1'b1;
    we    = 1'b0;
    expect_val("reset_release", 32'h0);

    // Basic write then read, and a neighbouring address with no clock.
    a = 32'd3; d = 32'h12345678; we = 1'b1;
    tick();
    we = 1'b0;
    expect_val("write_read", 32'h12345678);
    a = 32'd4;
    expect_val("comb_read_other", 32'h0);

    // Read-during-write: old data before the edge, new data after.
    a = 32'd3; d = 32'hA5A5A5A5; we = 1'b1;
    expect_val("rdw_before", 32'h12345678);
    tick();
    expect_val("rdw_after", 32'hA5A5A5A5);

    a = 32'd3; d = 32'hFFFFFFFF; we = 1'b0;
    repeat (3) tick();
    expect_val("we0_hold", 32'hA5A5A5A5);

    // Boundaries.
    a = 32'd63; d = 32'h00000063; we = 1'b1;
    tick();
    we = 1'b0;
    expect_val("top_word", 32'h00000063);
    a = 32'd64; d = 32'h11111111; we = 1'b1;
    tick();
    we = 1'b0;
    expect_val("oob_read", 32'h0);
    a = 32'd0;
    expect_val("no_wrap_0", 32'h0);
    a = 32'h40000003; d = 32'h22222222; we = 1'b1;
    tick();
    we = 1'b0;
    expect_val("upper_bits", 32'h0);
    a = 32'd3;
    expect_val("no_alias_3", 32'hA5A5A5A5);

    // Async reset between edges clears immediately and blocks writes.
    #3;
    rst_n = 1'b0;
    model_clear();
    expect_val("async_rst_now", 32'h0);
    we = 1'b1; d = 32'h77777777;
    tick();
    we = 1'b0;
    rst_n = 1'b1;
    expect_val("post_rst_3", 32'h0);
    a = 32'd63;
    expect_val("post_rst_63", 32'h0);

    // Reset asserted on the same edge as a write: the write is lost.
    a = 32'd7; d = 32'hCAFEF00D; we = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    expect_val("rst_edge_write", 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_clear();
        expect_val("rnd_rst", 32'h0);
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom() | 32'h0000_0040;
      else        a = $urandom_range(0, 79);
      we = $urandom_range(0, 1) == 1;
      d  = $urandom();
      expect_model("rnd_pre");
      tick();
      expect_model("rnd_post");
      we = 1'b0;
      a  = $urandom_range(0, 63);
      expect_model("rnd_read");
    end

    #5;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
